// File: rtl/sfp_clip_monitor_if.sv
// Bus bundle for sfp_clip_monitor: sample stream in, window statistics out.
// Signal prefixes are from the monitor's point of view (i_ = into the monitor).
interface sfp_clip_monitor_if #(
  parameter int IW   = 4,
  parameter int QW   = 4,
  parameter int CNTW = 4
);
  localparam int WL = IW + QW;

  logic            i_en;
  logic            i_in_valid;
  logic [WL-1:0]   i_in_val;        // two's complement, IW integer bits incl. sign
  logic            i_clipping;
  logic            i_clear;
  logic [WL-1:0]   o_peak;          // same format as i_in_val, always >= 0
  logic [CNTW-1:0] o_clip_cnt;
  logic            o_win_done;
  logic            o_overload;
  logic            o_overload_sticky;

  modport master (
    output i_en, i_in_valid, i_in_val, i_clipping, i_clear,
    input  o_peak, o_clip_cnt, o_win_done, o_overload, o_overload_sticky
  );

  modport slave (
    input  i_en, i_in_valid, i_in_val, i_clipping, i_clear,
    output o_peak, o_clip_cnt, o_win_done, o_overload, o_overload_sticky
  );
endinterface

// File: rtl/sfp_clip_monitor.sv
// Windowed overload monitor: per WIN accepted samples, publishes the clip
// count, the peak magnitude of the pre-resize sample and an overload flag.
module sfp_clip_monitor #(
  parameter int WIN    = 1024,
  parameter int THRESH = 16,
  parameter int IW     = 4,
  parameter int QW     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sfp_clip_monitor_if.slave    bus
);
  localparam int WL   = IW + QW;
  localparam int CNTW = $clog2(WIN + 1);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIN - 1);
  localparam logic [CNTW-1:0] THR      = CNTW'(THRESH);
  localparam logic [WL-1:0]   MAXPOS   = {1'b0, {(WL-1){1'b1}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_next;
  logic [CNTW-1:0] r_samp_cnt, r_clip_acc;
  logic [WL-1:0]   r_peak_acc;
  logic [WL-1:0]   r_peak;
  logic [CNTW-1:0] r_clip_cnt;
  logic            r_win_done, r_overload, r_sticky;

  logic            w_accept, w_last, w_drop, w_ovl;
  logic [WL:0]     w_ext, w_abs;
  logic [WL-1:0]   w_mag, w_peak_tot;
  logic [CNTW-1:0] w_clip_tot;

  // Next-state logic: en alone moves between idle and running.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_en)  w_next = S_RUN;
      S_RUN:   if (!bus.i_en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Magnitude at WL+1 bits so |most-negative| is representable, then clamp
  // to max positive; running totals including the current sample.
  always_comb begin
    w_ext      = {bus.i_in_val[WL-1], bus.i_in_val};
    w_abs      = w_ext[WL] ? (~w_ext + 1'b1) : w_ext;
    w_mag      = (|w_abs[WL:WL-1]) ? MAXPOS : w_abs[WL-1:0];
    w_peak_tot = (w_mag > r_peak_acc) ? w_mag : r_peak_acc;
    w_clip_tot = r_clip_acc + {{(CNTW-1){1'b0}}, bus.i_clipping};
    w_accept   = (r_state == S_RUN) && bus.i_in_valid;
    w_last     = w_accept && (r_samp_cnt == LAST_IDX);
    w_drop     = (r_state == S_RUN) && !bus.i_en;
    w_ovl      = (w_clip_tot >= THR);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Accumulators and published window statistics. A closing window wins over
  // a simultaneous en drop since its last sample was already accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_samp_cnt <= '0;
      r_clip_acc <= '0;
      r_peak_acc <= '0;
      r_peak     <= '0;
      r_clip_cnt <= '0;
      r_overload <= 1'b0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (w_last) begin
        r_peak     <= w_peak_tot;
        r_clip_cnt <= w_clip_tot;
        r_overload <= w_ovl;
        r_win_done <= 1'b1;
        r_samp_cnt <= '0;
        r_clip_acc <= '0;
        r_peak_acc <= '0;
      end else if (w_drop) begin
        r_samp_cnt <= '0;
        r_clip_acc <= '0;
        r_peak_acc <= '0;
      end else if (w_accept) begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
        r_clip_acc <= w_clip_tot;
        r_peak_acc <= w_peak_tot;
      end
    end
  end

  // Sticky overload: a new overload window beats a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)                r_sticky <= 1'b0;
    else if (w_last && w_ovl) r_sticky <= 1'b1;
    else if (bus.i_clear)     r_sticky <= 1'b0;
  end

  assign bus.o_peak            = r_peak;
  assign bus.o_clip_cnt        = r_clip_cnt;
  assign bus.o_win_done        = r_win_done;
  assign bus.o_overload        = r_overload;
  assign bus.o_overload_sticky = r_sticky;
endmodule

// File: tb/tb_sfp_clip_monitor.sv
// Directed bench for sfp_clip_monitor: WIN=8, THRESH=3, samples in Q4.4.
module tb_sfp_clip_monitor;
  localparam int WIN = 8, THRESH = 3, IW = 4, QW = 4, CNTW = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sfp_clip_monitor_if #(.IW(IW), .QW(QW), .CNTW(CNTW)) bus ();

  sfp_clip_monitor #(.WIN(WIN), .THRESH(THRESH), .IW(IW), .QW(QW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic c);
    bus.i_in_valid = 1'b1;
    bus.i_in_val   = v;
    bus.i_clipping = c;
    step();
  endtask

  task automatic idle_in();
    bus.i_in_valid = 1'b0;
    bus.i_in_val   = 8'h00;
    bus.i_clipping = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_en = 1'b0; bus.i_clear = 1'b0; idle_in();
    i_rst = 1'b1; step(); step(); i_rst = 1'b0;
    tests++; if (bus.o_peak !== 8'h00) begin fails++; $display("FAIL rst_peak got %h exp 00", bus.o_peak); end
    tests++; if (bus.o_clip_cnt !== 4'd0) begin fails++; $display("FAIL rst_clip got %0d exp 0", bus.o_clip_cnt); end
    tests++; if ({bus.o_win_done, bus.o_overload, bus.o_overload_sticky} !== 3'b000) begin
      fails++; $display("FAIL rst_flags got %b exp 000", {bus.o_win_done, bus.o_overload, bus.o_overload_sticky}); end
  endtask

  // 8 samples, clips on samples 2 and 5; peak |.| is 2.0 (0x20).
  task automatic test_basic_window();
    logic [7:0] v [8];
    v = '{8'h10, 8'hF0, 8'h20, 8'h08, 8'hE8, 8'h04, 8'h00, 8'h18};
    bus.i_en = 1'b1; step();               // enable transition
    for (int i = 0; i < 8; i++) begin
      send(v[i], (i == 1) || (i == 4));
      if (i == 6) begin
        tests++; if (bus.o_win_done !== 1'b0) begin fails++; $display("FAIL basic_early_done got %b exp 0", bus.o_win_done); end
      end
    end
    tests++; if (bus.o_win_done !== 1'b1) begin fails++; $display("FAIL basic_done got %b exp 1", bus.o_win_done); end
    tests++; if (bus.o_clip_cnt !== 4'd2) begin fails++; $display("FAIL basic_clip got %0d exp 2", bus.o_clip_cnt); end
    tests++; if (bus.o_overload !== 1'b0) begin fails++; $display("FAIL basic_ovl got %b exp 0", bus.o_overload); end
    tests++; if (bus.o_peak !== 8'h20) begin fails++; $display("FAIL basic_peak got %h exp 20", bus.o_peak); end
    idle_in(); step();
    tests++; if (bus.o_win_done !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b exp 0", bus.o_win_done); end
  endtask

  // 3 clips (== THRESH), values include -5.25 (0xAC) and +3.0 (0x30).
  task automatic test_overload();
    logic [7:0] v [8];
    v = '{8'h10, 8'hAC, 8'h30, 8'hF8, 8'h00, 8'h40, 8'hC8, 8'h01};
    for (int i = 0; i < 8; i++) send(v[i], (i == 0) || (i == 3) || (i == 7));
    tests++; if (bus.o_clip_cnt !== 4'd3) begin fails++; $display("FAIL ovl_clip got %0d exp 3", bus.o_clip_cnt); end
    tests++; if (bus.o_overload !== 1'b1) begin fails++; $display("FAIL ovl_flag got %b exp 1", bus.o_overload); end
    tests++; if (bus.o_overload_sticky !== 1'b1) begin fails++; $display("FAIL ovl_sticky got %b exp 1", bus.o_overload_sticky); end
    tests++; if (bus.o_peak !== 8'h54) begin fails++; $display("FAIL ovl_peak got %h exp 54", bus.o_peak); end
  endtask

  // Back-to-back window (in_valid never dropped) with one -8.0 sample.
  task automatic test_most_negative();
    for (int i = 0; i < 8; i++) send((i == 4) ? 8'h80 : 8'h00, 1'b0);
    tests++; if (bus.o_win_done !== 1'b1) begin fails++; $display("FAIL neg_done got %b exp 1", bus.o_win_done); end
    tests++; if (bus.o_peak !== 8'h7F) begin fails++; $display("FAIL neg_peak got %h exp 7f", bus.o_peak); end
    tests++; if (bus.o_overload !== 1'b0) begin fails++; $display("FAIL neg_ovl got %b exp 0", bus.o_overload); end
    tests++; if (bus.o_overload_sticky !== 1'b1) begin fails++; $display("FAIL neg_sticky_hold got %b exp 1", bus.o_overload_sticky); end
    idle_in();
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 5; i++) send(8'h70, 1'b1);
    idle_in(); bus.i_en = 1'b0; step();     // partial window dropped
    bus.i_in_valid = 1'b1; bus.i_in_val = 8'h7F; bus.i_clipping = 1'b1;
    step();                                  // idle: ignored
    bus.i_en = 1'b1; step();                 // transition cycle: not accepted
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 1'b0);
      if (i == 6) begin
        tests++; if (bus.o_win_done !== 1'b0) begin fails++; $display("FAIL en_early_done got %b exp 0", bus.o_win_done); end
        tests++; if (bus.o_peak !== 8'h7F) begin fails++; $display("FAIL en_peak_retained got %h exp 7f", bus.o_peak); end
      end
    end
    tests++; if (bus.o_win_done !== 1'b1) begin fails++; $display("FAIL en_done got %b exp 1", bus.o_win_done); end
    tests++; if (bus.o_clip_cnt !== 4'd0) begin fails++; $display("FAIL en_clip got %0d exp 0", bus.o_clip_cnt); end
    tests++; if (bus.o_peak !== 8'h08) begin fails++; $display("FAIL en_peak got %h exp 08", bus.o_peak); end
    idle_in();
  endtask

  task automatic test_clear_collision();
    bus.i_clear = 1'b1; step(); bus.i_clear = 1'b0;
    tests++; if (bus.o_overload_sticky !== 1'b0) begin fails++; $display("FAIL clr_plain got %b exp 0", bus.o_overload_sticky); end
    for (int i = 0; i < 7; i++) send(8'h10, i < 2);
    bus.i_clear = 1'b1; send(8'h10, 1'b1);   // clear coincides with overload close
    tests++; if (bus.o_overload_sticky !== 1'b1) begin fails++; $display("FAIL clr_collide got %b exp 1", bus.o_overload_sticky); end
    tests++; if (bus.o_overload !== 1'b1) begin fails++; $display("FAIL clr_ovl got %b exp 1", bus.o_overload); end
    idle_in(); step();                       // clear still high
    bus.i_clear = 1'b0;
    tests++; if (bus.o_overload_sticky !== 1'b0) begin fails++; $display("FAIL clr_next got %b exp 0", bus.o_overload_sticky); end
    tests++; if (bus.o_overload !== 1'b1) begin fails++; $display("FAIL clr_ovl_hold got %b exp 1", bus.o_overload); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) send(8'h20, 1'b1);
    i_rst = 1'b1; send(8'h20, 1'b1);
    i_rst = 1'b0;
    tests++; if ({bus.o_peak, bus.o_clip_cnt} !== 12'h000) begin fails++; $display("FAIL mrst_data got %h exp 000", {bus.o_peak, bus.o_clip_cnt}); end
    tests++; if ({bus.o_win_done, bus.o_overload, bus.o_overload_sticky} !== 3'b000) begin
      fails++; $display("FAIL mrst_flags got %b exp 000", {bus.o_win_done, bus.o_overload, bus.o_overload_sticky}); end
    bus.i_en = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h20, 1'b1); // idle: nothing accepted
    tests++; if (bus.o_win_done !== 1'b0) begin fails++; $display("FAIL mrst_idle_done got %b exp 0", bus.o_win_done); end
    bus.i_en = 1'b1; send(8'h20, 1'b1);          // transition cycle
    for (int i = 0; i < 8; i++) begin
      send(8'h30, 1'b1);
      if (i == 6) begin
        tests++; if (bus.o_win_done !== 1'b0) begin fails++; $display("FAIL mrst_early_done got %b exp 0", bus.o_win_done); end
      end
    end
    tests++; if (bus.o_win_done !== 1'b1) begin fails++; $display("FAIL mrst_done got %b exp 1", bus.o_win_done); end
    tests++; if (bus.o_clip_cnt !== 4'd8) begin fails++; $display("FAIL mrst_clip got %0d exp 8", bus.o_clip_cnt); end
    tests++; if (bus.o_peak !== 8'h30) begin fails++; $display("FAIL mrst_peak got %h exp 30", bus.o_peak); end
    idle_in(); step();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_overload();
    test_most_negative();
    test_enable_drop();
    test_clear_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
